// File: rtl/debounce_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : debounce_array                                               |
// | Description : W-channel switch conditioner with two-flop synchroniser,     |
// |               stability filter, registered rise/fall pulses and optional   |
// |               hold auto-repeat (enabled by `define DEBOUNCE_REPEAT_EN).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module debounce_array #(
   parameter int W          = 8,
   parameter int CNT_VLU    = 1000,
   parameter int REPEAT_DLY = 500000,
   parameter int REPEAT_PER = 100000
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic [W-1:0] in,
   output logic [W-1:0] out,
   output logic [W-1:0] rise,
   output logic [W-1:0] fall,
   output logic [W-1:0] rpt,
   output logic         any_change
);

   localparam int               CNT_W    = (CNT_VLU > 1) ? $clog2(CNT_VLU) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_VLU - 1);

`ifdef DEBOUNCE_REPEAT_EN
   localparam int                HOLD_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int                HOLD_W   = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
   localparam logic [HOLD_W-1:0] DLY_LAST = HOLD_W'(REPEAT_DLY - 1);
   localparam logic [HOLD_W-1:0] PER_LAST = HOLD_W'(REPEAT_PER - 1);
`endif

   if (W < 1 || CNT_VLU < 1 || REPEAT_DLY < 1 || REPEAT_PER < 1) begin : g_param_check
      $error("debounce_array: all parameters must be >= 1");
   end

   logic [W-1:0] s1;
   logic [W-1:0] s2;
   logic [W-1:0] accept;

   always_ff @(posedge clk) begin
      if (!rstn) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= in;
         s2 <= s1;
      end
   end

   for (genvar i = 0; i < W; i++) begin : g_chan
      logic [CNT_W-1:0] cnt;
      logic             out_q;
      logic             rise_q;
      logic             fall_q;
      logic             pending;

      assign pending   = s2[i] ^ out_q;
      assign accept[i] = pending && (cnt == CNT_LAST);

      // A mismatch that disappears before the count completes restarts from zero.
      always_ff @(posedge clk) begin
         if (!rstn) begin
            cnt    <= '0;
            out_q  <= 1'b0;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
         end else begin
            rise_q <= accept[i] & s2[i];
            fall_q <= accept[i] & ~s2[i];
            if (!pending || accept[i]) begin
               cnt <= '0;
            end else begin
               cnt <= cnt + CNT_W'(1);
            end
            if (accept[i]) begin
               out_q <= s2[i];
            end
         end
      end

      assign out[i]  = out_q;
      assign rise[i] = rise_q;
      assign fall[i] = fall_q;

`ifdef DEBOUNCE_REPEAT_EN
      logic [HOLD_W-1:0] hold;
      logic              periodic;
      logic              rpt_q;
      logic              hold_hit;

      assign hold_hit = periodic ? (hold == PER_LAST) : (hold == DLY_LAST);

      // Any edge with out low, or the edge accepting a fall, rearms the delay.
      always_ff @(posedge clk) begin
         if (!rstn || !out_q || accept[i]) begin
            hold     <= '0;
            periodic <= 1'b0;
            rpt_q    <= 1'b0;
         end else if (hold_hit) begin
            hold     <= '0;
            periodic <= 1'b1;
            rpt_q    <= 1'b1;
         end else begin
            hold     <= hold + HOLD_W'(1);
            rpt_q    <= 1'b0;
         end
      end

      assign rpt[i] = rpt_q;
`endif
   end

`ifndef DEBOUNCE_REPEAT_EN
   assign rpt = '0;
`endif

   always_ff @(posedge clk) begin
      if (!rstn) begin
         any_change <= 1'b0;
      end else begin
         any_change <= |accept;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_debounce_array.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_debounce_array                                            |
// | Description : Self-checking bench for debounce_array (W=4, CNT_VLU=8).     |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_debounce_array;

   localparam int W   = 4;
   localparam int CNT = 8;
   localparam int DLY = 20;
   localparam int PER = 5;

   logic         clk = 1'b0;
   logic         rstn = 1'b0;
   logic [W-1:0] in = '0;
   logic [W-1:0] out, rise, fall, rpt;
   logic         any_change;

   int checks = 0;
   int errors = 0;

   debounce_array #(
      .W(W), .CNT_VLU(CNT), .REPEAT_DLY(DLY), .REPEAT_PER(PER)
   ) dut (
      .clk(clk), .rstn(rstn), .in(in), .out(out), .rise(rise),
      .fall(fall), .rpt(rpt), .any_change(any_change)
   );

   always #5 clk = ~clk;

   // Reference model: a level is accepted once it has been seen (two edges late)
   // differing from the output for CNT consecutive edges.
   logic [W-1:0] m_s1 = '0, m_s2 = '0;
   logic [W-1:0] exp_out = '0, exp_rise = '0, exp_fall = '0, exp_rpt = '0;
   logic         exp_any = 1'b0;
   int           since[W];
   int           edge_n = 0;
`ifdef DEBOUNCE_REPEAT_EN
   int           rise_t[W];
`endif

   function automatic void model_edge();
      logic [W-1:0] n_out;
      logic         fell;
      n_out    = exp_out;
      exp_rise = '0;
      exp_fall = '0;
      exp_rpt  = '0;
      if (!rstn) begin
         m_s1    = '0;
         m_s2    = '0;
         exp_out = '0;
         exp_any = 1'b0;
         for (int i = 0; i < W; i++) since[i] = -1;
      end else begin
         for (int i = 0; i < W; i++) begin
            fell = 1'b0;
            if (m_s2[i] !== exp_out[i]) begin
               if (since[i] < 0) since[i] = edge_n;
               if (edge_n - since[i] + 1 == CNT) begin
                  since[i] = -1;
                  n_out[i] = m_s2[i];
                  if (m_s2[i]) begin
                     exp_rise[i] = 1'b1;
`ifdef DEBOUNCE_REPEAT_EN
                     rise_t[i] = edge_n;
`endif
                  end else begin
                     exp_fall[i] = 1'b1;
                     fell        = 1'b1;
                  end
               end
            end else begin
               since[i] = -1;
            end
`ifdef DEBOUNCE_REPEAT_EN
            if (exp_out[i] && !fell) begin
               int d;
               d = edge_n - rise_t[i];
               if (d == DLY || (d > DLY && (d - DLY) % PER == 0)) exp_rpt[i] = 1'b1;
            end
`endif
         end
         exp_any = |(exp_rise | exp_fall);
         exp_out = n_out;
         m_s2    = m_s1;
         m_s1    = in;
      end
      edge_n++;
   endfunction

   // Advance one clock; inputs only ever change 1 time unit after an edge.
   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      in   = '0;
      repeat (3) begin
         tick();
         if ({out, rise, fall, rpt, any_change} !== 17'd0) begin
            errors++;
            $display("FAIL reset_zero got=%h exp=0", {out, rise, fall, rpt, any_change});
         end
         checks++;
      end
      rstn = 1'b1;
      repeat (3) begin
         tick();
         if ({out, rise, fall, rpt, any_change} !== {exp_out, exp_rise, exp_fall, exp_rpt, exp_any}) begin
            errors++;
            $display("FAIL reset_model got=%h exp=%h", {out, rise, fall, rpt, any_change},
                     {exp_out, exp_rise, exp_fall, exp_rpt, exp_any});
         end
         checks++;
      end
   endtask

   task automatic test_single_rise();
      in = 4'b0001;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (out[0] !== (k >= 9) || rise !== ((k == 9) ? 4'b0001 : 4'b0000) ||
             any_change !== (k == 9)) begin
            errors++;
            $display("FAIL single_rise k=%0d got out=%b rise=%b any=%b exp out0=%0d rise_at=9",
                     k, out, rise, any_change, (k >= 9));
         end
         checks++;
      end
      in = '0;
      repeat (12) begin
         tick();
         if ({out, rise, fall, rpt, any_change} !== {exp_out, exp_rise, exp_fall, exp_rpt, exp_any}) begin
            errors++;
            $display("FAIL single_release got=%h exp=%h", {out, rise, fall, rpt, any_change},
                     {exp_out, exp_rise, exp_fall, exp_rpt, exp_any});
         end
         checks++;
      end
   endtask

   task automatic test_bounce();
      int rises;
      rises = 0;
      in[1] = 1'b1;
      repeat (5) begin
         tick();
         if (rise[1]) rises++;
      end
      in[1] = 1'b0;
      tick();
      if (rise[1]) rises++;
      in[1] = 1'b1;
      for (int k = 0; k < 15; k++) begin
         tick();
         if (rise[1]) rises++;
         if (rise[1] !== (k == 9)) begin
            errors++;
            $display("FAIL bounce_timing k=%0d got rise1=%b exp=%0d", k, rise[1], (k == 9));
         end
         checks++;
      end
      if (rises != 1) begin
         errors++;
         $display("FAIL bounce_count got=%0d exp=1", rises);
      end
      checks++;
      in[1] = 1'b0;
      repeat (12) tick();
      if (out !== 4'b0000) begin
         errors++;
         $display("FAIL bounce_release got=%b exp=0000", out);
      end
      checks++;
   endtask

   task automatic test_glitch();
      in[2] = 1'b1;
      repeat (7) tick();
      in[2] = 1'b0;
      repeat (15) begin
         tick();
         if (out[2] !== 1'b0 || rise[2] !== 1'b0 || fall[2] !== 1'b0) begin
            errors++;
            $display("FAIL glitch got out2=%b rise2=%b fall2=%b exp=0", out[2], rise[2], fall[2]);
         end
         checks++;
      end
   endtask

   task automatic test_simultaneous();
      int nr, nf;
      nr = 0;
      nf = 0;
      in = 4'b1111;
      repeat (14) begin
         tick();
         if (rise == 4'b1111) nr++;
         if ((rise !== 4'b0000 && rise !== 4'b1111) || (rise & fall) !== 4'b0000) begin
            errors++;
            $display("FAIL simul_rise got rise=%b fall=%b exp=all_or_none", rise, fall);
         end
         checks++;
      end
      in = 4'b0000;
      repeat (14) begin
         tick();
         if (fall == 4'b1111) nf++;
         if ((fall !== 4'b0000 && fall !== 4'b1111) || (rise & fall) !== 4'b0000) begin
            errors++;
            $display("FAIL simul_fall got rise=%b fall=%b exp=all_or_none", rise, fall);
         end
         checks++;
      end
      if (nr != 1 || nf != 1) begin
         errors++;
         $display("FAIL simul_count got rises=%0d falls=%0d exp=1,1", nr, nf);
      end
      checks++;
   endtask

   task automatic test_repeat();
      logic fallen;
      in = 4'b1000;
      for (int k = 0; k < 10; k++) tick();
      if (rise[3] !== 1'b1) begin
         errors++;
         $display("FAIL repeat_rise got=%b exp=1", rise[3]);
      end
      checks++;
      for (int j = 1; j <= 40; j++) begin
         logic e;
`ifdef DEBOUNCE_REPEAT_EN
         e = (j >= DLY) && ((j - DLY) % PER == 0);
`else
         e = 1'b0;
`endif
         tick();
         if (rpt[3] !== e || rpt[2:0] !== 3'b000) begin
            errors++;
            $display("FAIL repeat_hold j=%0d got rpt=%b exp rpt3=%b", j, rpt, e);
         end
         checks++;
      end
      in     = 4'b0000;
      fallen = 1'b0;
      repeat (15) begin
         tick();
         if (fall[3]) fallen = 1'b1;
         if ((fallen && rpt[3] !== 1'b0) ||
             {out, rise, fall, rpt, any_change} !== {exp_out, exp_rise, exp_fall, exp_rpt, exp_any}) begin
            errors++;
            $display("FAIL repeat_release got=%h exp=%h", {out, rise, fall, rpt, any_change},
                     {exp_out, exp_rise, exp_fall, exp_rpt, exp_any});
         end
         checks++;
      end
   endtask

   task automatic test_reset_mid();
      in = 4'b0001;
      repeat (8) tick();
      rstn = 1'b0;
      tick();
      if ({out, rise, fall, rpt, any_change} !== 17'd0) begin
         errors++;
         $display("FAIL midreset_zero got=%h exp=0", {out, rise, fall, rpt, any_change});
      end
      checks++;
      rstn = 1'b1;
      for (int k = 0; k < 12; k++) begin
         tick();
         if (out[0] !== (k >= 9) || rise[0] !== (k == 9)) begin
            errors++;
            $display("FAIL midreset_rise k=%0d got out0=%b rise0=%b exp out0=%0d",
                     k, out[0], rise[0], (k >= 9));
         end
         checks++;
      end
      in = '0;
      repeat (12) tick();
   endtask

   task automatic test_random();
      for (int n = 0; n < 800; n++) begin
         for (int i = 0; i < W; i++) begin
            if ($urandom_range(0, 11) == 0) in[i] = ~in[i];
         end
         rstn = ($urandom_range(0, 299) != 0);
         tick();
         if ({out, rise, fall, rpt, any_change} !== {exp_out, exp_rise, exp_fall, exp_rpt, exp_any}) begin
            errors++;
            $display("FAIL random n=%0d got=%h exp=%h", n, {out, rise, fall, rpt, any_change},
                     {exp_out, exp_rise, exp_fall, exp_rpt, exp_any});
         end
         checks++;
      end
      rstn = 1'b1;
   endtask

   initial begin
      for (int i = 0; i < W; i++) since[i] = -1;
      test_reset();
      test_single_rise();
      test_bounce();
      test_glitch();
      test_simultaneous();
      test_repeat();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
